// File: rtl/flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter
//
// Shares the single flash read port between two requesters. Requester 0 is
// the weight/bias fetch path and requester 1 is a secondary fetch path.
// Only one read is in flight at a time. A read latches the address, strobes
// flash_ready, waits LATENCY cycles, captures flashData_out, and returns the
// word to the owner with a one-cycle rvalid pulse. When both requesters ask
// at once they are served in round-robin order.
//
// Handshake: a requester raises reqN with a stable addrN and holds both until
// it sees gntN, which is a one-cycle pulse. Dropping reqN before gntN
// withdraws the request. Once gntN has pulsed, later changes to reqN or addrN
// have no effect on that read, and rvalidN always follows it. If reqN is
// still high in the cycle that rvalidN pulses, that counts as a new request.
//
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   req0/addr0          requester 0 request and address
//   gnt0/rvalid0        requester 0 accept pulse and data-valid pulse
//   req1/addr1          requester 1 request and address
//   gnt1/rvalid1        requester 1 accept pulse and data-valid pulse
//   rdata               last captured flash word (shared by both requesters)
//   busy                high while a read is being sequenced
//   flash_ready         one-cycle read strobe to the flash
//   flash_address       registered read address to the flash
//   flashData_out       flash read data
//   dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//
// LATENCY must lie in 1..255 so that LATENCY-1 fits the 8-bit wait counter.
// -----------------------------------------------------------------------------
module flash_read_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              flash_ready,
  output logic [ADDR_W-1:0] flash_address,
  input  logic [DATA_W-1:0] flashData_out,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LC_LOAD = 8'(LATENCY - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [7:0]        r_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_flash_ready;
  logic [ADDR_W-1:0] r_flash_address;

  logic              w_arb_any;
  logic              w_arb_pick;
  logic [ADDR_W-1:0] w_arb_addr;

  // Round-robin: a lone request wins outright, and on a tie the requester
  // that was not served last wins.
  assign w_arb_any  = req0 | req1;
  assign w_arb_pick = (req0 & req1) ? ~r_last_grant : req1;
  assign w_arb_addr = w_arb_pick ? addr1 : addr0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_owner         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_cnt           <= '0;
      r_gnt0          <= 1'b0;
      r_gnt1          <= 1'b0;
      r_rvalid0       <= 1'b0;
      r_rvalid1       <= 1'b0;
      r_rdata         <= '0;
      r_busy          <= 1'b0;
      r_flash_ready   <= 1'b0;
      r_flash_address <= '0;
    end else begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_flash_ready <= 1'b0;
      case (r_state)
        // DONE arbitrates exactly like IDLE so that back-to-back reads do
        // not pass through an idle cycle.
        S_IDLE, S_DONE: begin
          if (w_arb_any) begin
            r_state         <= S_ISSUE;
            r_owner         <= w_arb_pick;
            r_last_grant    <= w_arb_pick;
            r_flash_address <= w_arb_addr;
            r_gnt0          <= ~w_arb_pick;
            r_gnt1          <= w_arb_pick;
            r_flash_ready   <= 1'b1;
            r_busy          <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LC_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_rdata   <= flashData_out;
            r_rvalid0 <= ~r_owner;
            r_rvalid1 <= r_owner;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0          = r_gnt0;
  assign gnt1          = r_gnt1;
  assign rvalid0       = r_rvalid0;
  assign rvalid1       = r_rvalid1;
  assign rdata         = r_rdata;
  assign busy          = r_busy;
  assign flash_ready   = r_flash_ready;
  assign flash_address = r_flash_address;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_read_arbiter
//
// Main instance (LATENCY=10) is checked every cycle against a cycle-schedule
// model: each accepted request at cycle k fixes gnt at k+1, the DONE/rvalid
// cycle at k+L+2, and the returned word as the flash data for the address.
// A second instance (LATENCY=1) is exercised with directed literal checks.
// -----------------------------------------------------------------------------
module tb_flash_read_arbiter;

  localparam int L = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, flash_ready;
  logic [15:0] rdata, flash_address;
  logic [15:0] flashData_out = '0;
  logic [1:0]  dbg_state;

  flash_read_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(L)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .flash_ready(flash_ready),
    .flash_address(flash_address), .flashData_out(flashData_out),
    .dbg_state(dbg_state)
  );

  // ---------------- LATENCY=1 DUT ----------------
  logic        b_req0 = 1'b0, b_req1 = 1'b0;
  logic [15:0] b_addr0 = '0, b_addr1 = '0;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_busy, b_fr;
  logic [15:0] b_rdata, b_faddr;
  logic [15:0] b_fdata = '0;
  logic [1:0]  b_dbg;

  flash_read_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst),
    .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .rvalid0(b_rv0),
    .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .rvalid1(b_rv1),
    .rdata(b_rdata), .busy(b_busy), .flash_ready(b_fr),
    .flash_address(b_faddr), .flashData_out(b_fdata),
    .dbg_state(b_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] data_of(input logic [15:0] a);
    if (a == 16'h0012) return 16'hBEEF;
    return a ^ 16'h5A3C;
  endfunction

  // ---------------- flash memory model ----------------
  // Presents the word for the strobed address exactly in cycle strobe+L and
  // noise otherwise, so a capture on the wrong cycle is visible.
  int          fr_cyc = 0;
  logic [15:0] fr_addr = '0;
  bit          fr_pend = 1'b0;
  always @(negedge clk) begin
    if (flash_ready) begin
      fr_cyc  = cyc;
      fr_addr = flash_address;
      fr_pend = 1'b1;
    end
    if (fr_pend && cyc == fr_cyc + L) begin
      flashData_out = data_of(fr_addr);
      fr_pend = 1'b0;
    end else begin
      flashData_out = 16'($urandom_range(0, 65535));
    end
  end

  // ---------------- behavioural model (cycle schedule) ----------------
  int          m_done = -1;   // cycle index of the current read's DONE cycle
  bit          m_last = 1'b1;
  bit          m_owner = 1'b0;
  bit          m_pick;
  logic [15:0] m_addr = '0;
  int          mk;
  logic        e_gnt0 = 0, e_gnt1 = 0, e_rv0 = 0, e_rv1 = 0, e_busy = 0, e_fr = 0;
  logic [15:0] e_rdata = '0, e_faddr = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_done = -1; m_last = 1'b1; m_owner = 1'b0;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_busy = 0; e_fr = 0;
      e_rdata = '0; e_faddr = '0;
    end else begin
      mk = cyc;  // cycle whose inputs were just sampled
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_fr = 0;
      if (mk + 1 == m_done) begin
        if (m_owner) e_rv1 = 1; else e_rv0 = 1;
        e_rdata = data_of(m_addr);
      end
      if (mk >= m_done && (req0 || req1)) begin
        m_pick  = (req0 && req1) ? !m_last : req1;
        m_last  = m_pick;
        m_owner = m_pick;
        m_addr  = m_pick ? addr1 : addr0;
        if (m_pick) e_gnt1 = 1; else e_gnt0 = 1;
        e_fr    = 1;
        e_faddr = m_addr;
        m_done  = mk + L + 2;
      end
      e_busy = (mk + 1 <= m_done);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("gnt0", gnt0, e_gnt0);
    chk("gnt1", gnt1, e_gnt1);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("busy", busy, e_busy);
    chk("flash_ready", flash_ready, e_fr);
    chk("flash_address", flash_address, e_faddr);
    chk("rdata", rdata, e_rdata);
  end

  // ---------------- event monitor ----------------
  int          g_who[$], g_cyc[$], g_fr[$], r_who[$], r_cyc[$];
  logic [15:0] g_addr[$], r_data[$];
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      g_who.push_back(gnt1 ? 1 : 0); g_cyc.push_back(cyc);
      g_addr.push_back(flash_address); g_fr.push_back(int'(flash_ready));
    end
    if (rvalid0 || rvalid1) begin
      r_who.push_back(rvalid1 ? 1 : 0); r_cyc.push_back(cyc); r_data.push_back(rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete(); g_fr.delete(); g_addr.delete();
    r_who.delete(); r_cyc.delete(); r_data.delete();
  endtask

  task automatic do_req(input int who, input logic [15:0] a);
    bit got = 1'b0;
    if (who == 0) begin req0 = 1'b1; addr0 = a; end
    else          begin req1 = 1'b1; addr1 = a; end
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if ((who == 0 && gnt0) || (who == 1 && gnt1)) got = 1'b1;
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    chk(who == 0 ? "gnt0_wait" : "gnt1_wait", got, 1);
  endtask

  task automatic wait_rv(input int n);
    for (int i = 0; i < 200 && r_who.size() < n; i++) tick();
    chk("rvalid_wait", r_who.size() >= n, 1);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int idle_seen;

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_faddr", flash_address, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_rdata", b_rdata, 0);
    n_rst = 1'b1;
    tick(); tick();

    // Single read
    clear_logs();
    t0 = cyc;
    do_req(0, 16'h0012);
    wait_rv(1);
    chk("t1_gnt_cyc", g_cyc[0] - t0, 1);
    chk("t1_gnt_who", g_who[0], 0);
    chk("t1_fr_at_gnt", g_fr[0], 1);
    chk("t1_addr", g_addr[0], 16'h0012);
    chk("t1_rv_cyc", r_cyc[0] - t0, 12);
    chk("t1_rdata", r_data[0], 16'hBEEF);
    chk("t1_rv_who", r_who[0], 0);
    tick(); tick(); tick();
    chk("t1_rv_count", r_who.size(), 1);

    // Tie after reset
    n_rst = 1'b0; tick(); n_rst = 1'b1; tick();
    clear_logs();
    fork
      do_req(0, 16'h0100);
      do_req(1, 16'h0200);
    join
    wait_rv(2);
    chk("t2_first_who", g_who[0], 0);
    chk("t2_first_addr", g_addr[0], 16'h0100);
    chk("t2_second_who", g_who[1], 1);
    chk("t2_second_addr", g_addr[1], 16'h0200);
    chk("t2_gnt1_after_rv0", g_cyc[1] - r_cyc[0], 1);
    chk("t2_rdata1", r_data[1], data_of(16'h0200));
    tick(); tick();

    // Fairness with both held
    clear_logs();
    idle_seen = 0;
    req0 = 1'b1; addr0 = 16'h0300; req1 = 1'b1; addr1 = 16'h0400;
    for (int i = 0; i < 100 && g_who.size() < 4; i++) begin
      tick();
      if (g_who.size() >= 1 && !busy) idle_seen++;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_rv(4);
    for (int i = 0; i < 4; i++) chk("t3_order", g_who[i], i % 2);
    for (int i = 1; i < 4; i++) chk("t3_spacing", g_cyc[i] - g_cyc[i-1], 12);
    chk("t3_no_idle", idle_seen, 0);
    tick(); tick();

    // Streaming on requester 1
    clear_logs();
    req1 = 1'b1; addr1 = 16'h0000;
    for (int i = 0; i < 100 && g_who.size() < 4; i++) begin
      tick();
      if (gnt1) addr1 = 16'(g_who.size());
    end
    req1 = 1'b0;
    wait_rv(4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_who", g_who[i], 1);
      chk("t4_addr", g_addr[i], 16'(i));
      chk("t4_data", r_data[i], data_of(16'(i)));
    end
    for (int i = 1; i < 4; i++) chk("t4_spacing", g_cyc[i] - g_cyc[i-1], 12);
    tick(); tick();

    // Reset mid-WAIT
    do_req(0, 16'h0055);
    clear_logs();
    for (int i = 0; i < 5; i++) tick();
    n_rst = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_faddr", flash_address, 0);
    chk("t5_rst_rdata", rdata, 0);
    chk("t5_rst_fr", flash_ready, 0);
    tick(); tick();
    n_rst = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t5_no_rvalid", r_who.size(), 0);
    t0 = cyc;
    do_req(0, 16'h0066);
    wait_rv(1);
    chk("t5_fresh_rv_cyc", r_cyc[0] - t0, 12);
    chk("t5_fresh_data", r_data[0], data_of(16'h0066));
    tick(); tick();

    // LATENCY=1 instance
    b_req0 = 1'b1; b_addr0 = 16'h0777; b_fdata = 16'h1111;
    tick();  // T+1
    chk("t6_gnt", b_gnt0, 1);
    chk("t6_fr", b_fr, 1);
    chk("t6_faddr", b_faddr, 16'h0777);
    b_req0 = 1'b0; b_fdata = 16'h1234;
    tick();  // T+2
    chk("t6_rv_early", b_rv0, 0);
    chk("t6_gnt_once", b_gnt0, 0);
    b_fdata = 16'hCAFE;
    tick();  // T+3
    chk("t6_rv", b_rv0, 1);
    chk("t6_rv1", b_rv1, 0);
    chk("t6_rdata", b_rdata, 16'hCAFE);
    b_fdata = 16'h2222;
    tick();  // T+4
    chk("t6_rv_gone", b_rv0, 0);
    chk("t6_idle", b_busy, 0);
    chk("t6_rdata_hold", b_rdata, 16'hCAFE);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single flash memory read port between two requesters and sequences each read through the fixed flash access latency.
- Requester 0 is the network controller's weight/bias fetch path; requester 1 is a secondary fetch path, e.g. a digit-detect or SPI readback path.
- Issues one transaction at a time: latches the address, strobes flash_ready, waits LATENCY cycles, captures flashData_out, and returns the word to the granted requester with a one-cycle valid pulse.
- Arbitration between the two requesters is round-robin.

Parameters:
- ADDR_W, 16: flash address width.
- DATA_W, 16: flash data word width.
- LATENCY, 10: cycles from the flash_ready strobe to flashData_out being valid. Legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 read request; held high until gnt0.
- addr0  in  ADDR_W  requester 0 address; must be stable while req0 is high.
- gnt0  out  1  one-cycle pulse: requester 0 transaction accepted.
- rvalid0  out  1  one-cycle pulse: rdata holds requester 0's word.
- req1  in  1  requester 1 read request.
- addr1  in  ADDR_W  requester 1 address.
- gnt1  out  1  one-cycle pulse: requester 1 accepted.
- rvalid1  out  1  one-cycle pulse: rdata holds requester 1's word.
- rdata  out  DATA_W  last captured flash word, shared by both requesters.
- busy  out  1  high in ISSUE, WAIT and DONE.
- flash_ready  out  1  one-cycle read strobe to flash memory.
- flash_address  out  ADDR_W  registered read address to flash.
- flashData_out  in  DATA_W  flash read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - All outputs go to 0, including rdata and flash_address.
  - last_grant is set to 1, so req0 wins the first tie.
  - Reset mid-transaction aborts it: no rvalid is produced, and the requester must re-request.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- Arbitration is evaluated in IDLE and in DONE:
  - Only req0 high: requester 0 is chosen.
  - Only req1 high: requester 1 is chosen.
  - Both high: the requester not equal to last_grant is chosen.
  - Neither high: go to (or stay in) IDLE.
  - When a requester is chosen: go to ISSUE, register the owner, set last_grant to the owner, and register flash_address from that requester's address.
- ISSUE (one cycle):
  - gnt of the owner is 1, flash_ready is 1.
  - The wait counter is loaded with LATENCY-1.
  - Next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, rdata is loaded with flashData_out and the next state is DONE.
- DONE (one cycle):
  - rvalid of the owner is 1.
  - Arbitration runs again, so back-to-back transactions proceed with no IDLE bubble.
- Timing: req sampled high in IDLE at cycle T gives:
  - gnt at T+1 (together with flash_ready);
  - rdata capture at the clock edge ending cycle T+LATENCY+1;
  - rvalid at T+LATENCY+2.
- A requester still holding req during its own DONE cycle counts as a new request.
- Only one of gnt0/gnt1 is ever high; likewise only one of rvalid0/rvalid1.
- gnt and rvalid never coincide with each other.
- flash_ready is high only in ISSUE. flash_address holds its value from ISSUE until the next ISSUE.
- A req dropping after gnt has no effect: the transaction completes and rvalid still pulses.
- A req dropping before gnt withdraws the request.
- Address changes on a req line after its gnt are ignored.
- rdata holds its value between captures.

Test Plan:
- Single read, LATENCY=10: req0=1 at T with addr0=0x0012; flash model returns 0xBEEF 10 cycles after flash_ready. Required: gnt0 and flash_ready at T+1, flash_address=0x0012, rvalid0 at T+12, rdata=0xBEEF, rvalid1 never asserts.
- Tie after reset: req0 and req1 both high, addr0=0x0100, addr1=0x0200, both held until gnt. Required: requester 0 served first (0x0100), then requester 1 served (0x0200), with gnt1 in the cycle directly after rvalid0.
- Fairness: both req0 and req1 held high continuously for 4 transactions. Required: grant order 0,1,0,1; busy stays 1 throughout; no IDLE cycles.
- Single requester streaming: req1 held high, addr1 stepping 0x0000→0x0003. Required: 4 back-to-back grants to requester 1, each 12 cycles apart, with rdata matching the flash model.
- Reset mid-WAIT: n_rst pulsed low 5 cycles after gnt0. Required: all outputs 0 immediately, no rvalid0; a fresh req0 afterwards completes normally.
- LATENCY=1 build: req0 at T. Required: gnt at T+1, rvalid at T+3, and rdata equals the flash data present at the edge ending T+2.
